// File: rtl/sevenseg_scan.sv
// sevenseg_scan: four-digit multiplexed seven-segment driver with blanking guard.
// Optional leading-zero blanking: define SEVENSEG_LEADING_ZERO_BLANK_EN.
//
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   en          : scan enable (low blanks display, holds counters)
//   load, value : one-cycle capture strobe and 16-bit value (nibble d -> digit d)
//   dp_mask     : live decimal-point enables, bit d -> digit d
//   seg, dp, an : active-low segments {g..a}, decimal point, anodes
//   frame_done  : one-cycle pulse at the start of each new frame
module sevenseg_scan #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLK_LIM = CW'(BLANK_CYCLES);

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_e;

  logic [15:0]   pending_q, pending_d;
  logic [15:0]   shown_q, shown_d;
  logic [1:0]    digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;
  phase_e        phase_d;
  logic [3:0]    nib;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  logic          lz;
`endif

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Next-state: counters advance only when enabled; load is always taken.
  always_comb begin
    pending_d = load ? value : pending_q;
    shown_d   = shown_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q;
    fd_d      = 1'b0;
    if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        digit_d = 2'(digit_q + 2'd1);
        if (digit_q == 2'd3) begin
          // pending_d already holds a same-cycle load, giving the bypass
          shown_d = pending_d;
          fd_d    = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Outputs are built from next-state so they line up with cnt/digit.
  always_comb begin
    phase_d = (cnt_d < BLK_LIM) ? PH_BLANK : PH_SHOW;
    nib     = shown_d[{digit_d, 2'b00} +: 4];
    seg_d   = 7'h7F;
    an_d    = 4'hF;
    dp_d    = 1'b1;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    lz      = (digit_d != 2'd0) &&
              ((shown_d >> {digit_d, 2'b00}) == 16'h0000);
`endif
    if (en && phase_d == PH_SHOW) begin
      an_d  = ~(4'b0001 << digit_d);
      seg_d = decode(nib);
      dp_d  = ~dp_mask[digit_d];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      if (lz) seg_d = 7'h7F;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 16'h0000;
      shown_q   <= 16'h0000;
      digit_q   <= 2'd0;
      cnt_q     <= '0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= 4'hF;
      fd_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      shown_q   <= shown_d;
      digit_q   <= digit_d;
      cnt_q     <= cnt_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: randomized + directed bench for sevenseg_scan.
// Reference model works from absolute enabled-cycle time.
module tb_sevenseg_scan;

  localparam int CD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  sevenseg_scan #(
    .CLK_DIV(CD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .load(load),
    .value(value),
    .dp_mask(dp_mask),
    .seg(seg),
    .dp(dp),
    .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int t = 0;
  logic [15:0] m_pend = 16'h0000;
  logic [15:0] m_shown = 16'h0000;
  logic [6:0] dec [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, 16'(an), 16'hF);
    chk({tag, "_seg"}, 16'(seg), 16'h7F);
    chk({tag, "_dp"}, 16'(dp), 16'h1);
    chk({tag, "_fd"}, 16'(frame_done), 16'h0);
  endtask

  // One clock: model the edge from the inputs sampled there, then compare.
  task automatic step();
    logic        l, e, bnd, ed;
    logic [15:0] v;
    logic [3:0]  m, ea;
    logic [6:0]  es;
    int          cnt, dg;
    l = load; e = en; v = value; m = dp_mask;
    bnd = 1'b0; es = 7'h7F; ea = 4'hF; ed = 1'b1;
    @(posedge clk);
    if (l) m_pend = v;
    if (e) begin
      t++;
      if (t % FR == 0) begin
        bnd = 1'b1;
        m_shown = m_pend;
      end
    end
    cnt = t % CD;
    dg  = (t / CD) % 4;
    if (e && cnt >= BC) begin
      ea = ~(4'b0001 << dg);
      es = dec[4'(m_shown >> (4 * dg))];
      ed = ~m[dg];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      if (dg != 0 && (m_shown >> (4 * dg)) == 16'h0000) es = 7'h7F;
`endif
    end
    #1;
    chk("an", 16'(an), 16'(ea));
    chk("seg", 16'(seg), 16'(es));
    chk("dp", 16'(dp), 16'(ed));
    chk("frame_done", 16'(frame_done), 16'(bnd));
    chk("an_onehot", 16'($countones(~an) <= 1), 16'h1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (40) step();

    value = 16'h12AF; load = 1'b1; step(); load = 1'b0;
    repeat (70) step();

    for (int i = 0; i < FR && ((t + 1) % FR) != 0; i++) step();
    value = 16'h8888; load = 1'b1; step(); load = 1'b0;
    repeat (12) step();
    value = 16'h1111; load = 1'b1; step(); load = 1'b0;
    repeat (2 * FR) step();

    for (int i = 0; i < 2 * FR && !(((t % FR) / CD) == 2 && (t % CD) == 3); i++)
      step();
    en = 1'b0;
    repeat (50) step();
    en = 1'b1;
    repeat (FR + 8) step();

    dp_mask = 4'b0100;
    repeat (FR) step();
    dp_mask = 4'b0000;

    value = 16'h0030; load = 1'b1; step(); load = 1'b0;
    repeat (2 * FR) step();

    repeat (3000) begin
      en = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
      step();
    end
    load = 1'b0;

    en = 1'b1;
    dp_mask = 4'b1111;
    repeat (13) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    t = 0;
    m_pend = 16'h0000;
    m_shown = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Multiplexed four-digit seven-segment display driver for the board wrapper. It is the output-side counterpart of the integration bench, which samples `seg`/`an`.
- It captures a 16-bit value from the core and scans it across four common-anode digits, one hex nibble per digit.
- It applies a blanking guard between digits to prevent ghosting.
- New values take effect only on frame boundaries, so a digit never tears mid-frame.

## Interface
- `CLK_DIV`, default 100000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, default 1000: leading cycles of each slot with all anodes off; must satisfy 1 ≤ `BLANK_CYCLES` < `CLK_DIV`.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; low blanks the display and holds the counters.
- `load`  in  1  one-cycle strobe; captures `value` into the pending register.
- `value`  in  16  nibble d (`value[4d+3:4d]`) drives digit d; digit 0 is rightmost.
- `dp_mask`  in  4  bit d = 1 lights the decimal point of digit d; sampled live.
- `seg`  out  7  active-low segments, {g,f,e,d,c,b,a}.
- `dp`  out  1  active-low decimal point.
- `an`  out  4  active-low anodes; bit d selects digit d.
- `frame_done`  out  1  one-cycle pulse at the start of each new frame.

## Operation
- Registers:
  - `pending[15:0]`: written on `load`.
  - `shown[15:0]`: the value being displayed.
  - `digit[1:0]`: current digit slot.
  - `cnt`: slot counter, 0..`CLK_DIV`-1.
  - `phase`: BLANK or SHOW.
- Phase is derived from the counter:
  - BLANK while `cnt` < `BLANK_CYCLES`: `an`=4'hF, `seg`=7'h7F, `dp`=1.
  - SHOW otherwise: `an` = ~(1<<`digit`), `seg` = decode(`shown` nibble `digit`), `dp` = ~`dp_mask[digit]`.
- Transitions, with `en`=1 on every clock:
  - `cnt` increments.
  - At `cnt`=`CLK_DIV`-1, `cnt` wraps to 0 and `digit` increments mod 4.
  - When `digit` wraps 3→0, a frame boundary occurs: `shown` <= `pending` and `frame_done` pulses.
- Decode, active-low: 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- Boundary conditions:
  - `load` on the frame-boundary cycle: the new `value` bypasses straight into `shown` on that edge.
  - Multiple `load`s within one frame: the last one wins.
  - `load` is accepted regardless of `en`.
  - `en`=0: outputs are blanked on the next edge; `cnt`, `digit` and `shown` hold, and `frame_done`=0. When `en` returns to 1, scanning resumes from the held state.
  - Reset asserted mid-frame clears everything immediately, with no waiting for the slot to finish.

## Timing
- Reset values: `seg`=7'h7F, `dp`=1, `an`=4'hF, `frame_done`=0, `cnt`=0, `digit`=0, `pending`=`shown`=16'h0000.
- All outputs are registered and computed from next-state, so they are cycle-coherent with `cnt`/`digit`. There is no extra pipeline lag.
- Counting edges from the first edge after `rst_n` release with `en`=1:
  - Digit 0 is lit from edge `BLANK_CYCLES` through edge `CLK_DIV`-1.
  - Digit d is lit from edge d·`CLK_DIV`+`BLANK_CYCLES` through edge (d+1)·`CLK_DIV`-1.
  - Frame length is 4·`CLK_DIV` cycles.
- `frame_done` is high for exactly the cycle after each edge at which `digit` and `cnt` return to 0. The same edge updates `shown`.
- `load` to visible change: at most 4·`CLK_DIV` + `BLANK_CYCLES` cycles.
- At most one anode is low in any cycle.

## Configuration
- `SEVENSEG_LEADING_ZERO_BLANK_EN` defined:
  - During SHOW, digit d is blanked (`seg`=7'h7F, `an` still low, `dp` still honoured) when nibble d and all higher nibbles of `shown` are 0.
  - Digit 0 is never blanked, so 16'h0000 shows a single "0".
- Macro undefined: all four nibbles are always displayed, including leading zeros.

## Test plan
- Reset, with `CLK_DIV`=8 and `BLANK_CYCLES`=2:
  - Hold `rst_n`=0 → `an`=F, `seg`=7F, `dp`=1, `frame_done`=0.
  - Release with `en`=1 → `an`=4'b1110 first at edge 2, blank at edge 8, 4'b1101 at edge 10.
  - `frame_done` pulses only after edge 32.
- Frame-boundary update:
  - `load` `value`=16'h12AF mid-frame → digits keep showing 0 until the boundary.
  - Next frame shows `seg`=0E, 08, 24, 79 on digits 0..3.
- Bypass: `load` 16'h8888 on the exact boundary cycle → the following frame shows `seg`=7'h00 on all digits. A `load` of 16'h1111 later in the same frame appears only in the next frame.
- Enable:
  - Drop `en` during digit 2 SHOW → `an`=F on the next edge.
  - Raise `en` 50 cycles later → digit 2 resumes with the remaining slot count, and frame length excluding the pause is 32.
- Decimal point and async reset:
  - `dp_mask`=4'b0100 → `dp`=0 only while `an`=4'b1011.
  - Assert `rst_n` low mid-slot → all outputs return to reset values without waiting for a clock edge.
- `SEVENSEG_LEADING_ZERO_BLANK_EN` defined, `value`=16'h0030 → digits 3 and 2 are blank (`seg`=7F), digit 1 shows 7'h30, digit 0 shows 7'h40.
